sprite_cmd_scheduler: RTL

//  Upstream feeder for the sprite display blocks; one cmd_out drives every display block in parallel.

---
 rtl/sprite_cmd_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sprite_cmd_scheduler.sv
// Command FIFO + ping-pong flush scheduler feeding the sprite display blocks.
// Optional flush-done interrupt: define SPRITE_CMD_IRQ_EN.
module sprite_cmd_scheduler #(
  parameter int DEPTH    = 16,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        irq,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_vblank_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_VB = 2'd1, S_FLUSH = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [32:0]     mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            back_q, ff_q, ovf_q, bad_q, irq_q;
  logic            back_d, ff_d, ovf_d, bad_d;
  logic [31:0]     stage_q, stage_d, cmd_q, rdata_q, rdata_d, status;
  logic [32:0]     head, push_data;
  logic            empty, full, pop, push, push_req, bad_set, ovf_set, clr_flags, in_vblank;

  // Writes are never back-pressured: a push either lands this cycle or is dropped and flagged.
  assign head      = mem_q[rd_ptr_q];
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign in_vblank = (vcount >= 10'(V_ACTIVE));
  assign bad_set   = chipselect && write && (address == 2'd0) && (writedata[20:17] == 4'b1111);
  assign push_req  = chipselect && write && (((address == 2'd0) && !bad_set) || (address == 2'd1));
  assign push      = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign clr_flags = chipselect && write && (address == 2'd3);
  assign push_data = (address == 2'd1) ? {1'b1, 32'h0} : {1'b0, writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!empty && head[32]) state_d = S_WAIT_VB;
      S_WAIT_VB: if (in_vblank && !ff_q) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    stage_d = 32'h0;
    case (state_q)
      S_IDLE: if (!empty && !head[32]) begin
        pop     = 1'b1;
        stage_d = {head[31:14], back_q, head[12:0]};
      end
      S_FLUSH: begin
        pop     = 1'b1;
        stage_d = {6'd0, 5'd0, 4'b1111, 3'd0, back_q, 13'd0};
      end
      default: ;
    endcase
  end

  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
    back_d  = (state_q == S_FLUSH) ? ~back_q : back_q;
    // One swap per frame: armed again only when the frame restarts at line 0.
    ff_d    = (state_q == S_FLUSH) ? 1'b1 : ((vcount == 10'd0) ? 1'b0 : ff_q);
    ovf_d   = clr_flags ? 1'b0 : (ovf_q | ovf_set);
    bad_d   = clr_flags ? 1'b0 : (bad_q | bad_set);
    status  = {19'd0, irq_q, bad_q, ovf_q, (state_q != S_IDLE), back_q, 8'(level_q)};
    rdata_d = (chipselect && read) ? status : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      back_q   <= 1'b1;
      ff_q     <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      stage_q  <= 32'h0;
      cmd_q    <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      level_q <= level_d;
      back_q  <= back_d;
      ff_q    <= ff_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      stage_q <= stage_d;
      cmd_q   <= stage_q;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef SPRITE_CMD_IRQ_EN
  // Set wins over an acknowledge landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   irq_q <= 1'b0;
    else if (state_q == S_FLUSH) irq_q <= 1'b1;
    else if (chipselect && write && (address == 2'd2)) irq_q <= 1'b0;
  end
`else
  assign irq_q = 1'b0;
`endif

  assign cmd_out      = cmd_q;
  assign readdata     = rdata_q;
  assign irq          = irq_q;
  assign dbg_state_o  = state_q;
  assign dbg_vblank_o = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
endmodule
